// File: rtl/buffer_write_arbiter_if.sv
// Handshake and buffer-write bundle between the command handler, the
// clear sequencer and the character buffer.
//   master: drives cmd_*/clr_*_req/clr_row_start, observes status and writes
//   slave : the arbiter; drives cmd_ready, clr_busy, clr_done, buf_*
interface buffer_write_arbiter_if #(
   parameter int ADDR_BITS = 11
) ();
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [7:0]           cmd_char;
   logic [ADDR_BITS-1:0] cmd_addr;
   logic                 clr_row_req;
   logic [ADDR_BITS-1:0] clr_row_start;
   logic                 clr_all_req;
   logic                 clr_busy;
   logic                 clr_done;
   logic [7:0]           buf_din;
   logic [ADDR_BITS-1:0] buf_waddr;
   logic                 buf_wen;

   modport master (
      output cmd_valid, cmd_char, cmd_addr,
      output clr_row_req, clr_row_start, clr_all_req,
      input  cmd_ready, clr_busy, clr_done,
      input  buf_din, buf_waddr, buf_wen
   );

   modport slave (
      input  cmd_valid, cmd_char, cmd_addr,
      input  clr_row_req, clr_row_start, clr_all_req,
      output cmd_ready, clr_busy, clr_done,
      output buf_din, buf_waddr, buf_wen
   );
endinterface

// File: rtl/buffer_write_arbiter.sv
// Arbitrates char-buffer writes between command writes and row/all clears.
// Ports: clk, reset (sync, active-high), bus (slave side of the bundle).
module buffer_write_arbiter #(
   parameter int         ROWS      = 25,
   parameter int         COLS      = 80,
   parameter int         ADDR_BITS = 11,
   parameter logic [7:0] FILL_CHAR = 8'h20
) (
   input logic             clk,
   input logic             reset,
   buffer_write_arbiter_if.slave bus
);
   localparam int N  = ROWS * COLS;
   localparam int CW = ADDR_BITS + 1;
   localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(N - 1);

   typedef enum logic [1:0] {IDLE, CLR_ROW, CLR_ALL} state_t;

   state_t               state, state_n;
   logic [ADDR_BITS-1:0] addr, addr_n;
   logic [CW-1:0]        cnt, cnt_n;
   logic                 pend, pend_n;
   logic [ADDR_BITS-1:0] pend_start, pend_start_n;
   logic                 wen, wen_n;
   logic [ADDR_BITS-1:0] waddr, waddr_n;
   logic [7:0]           din, din_n;
   logic                 done, done_n;

   // Clear-write issue control: wr issues a fill write at wr_addr;
   // fresh restarts the write count for a new clear.
   logic                 wr, fresh;
   logic [ADDR_BITS-1:0] wr_addr;
   logic                 row_ok;

   function automatic logic [ADDR_BITS-1:0] wrap(
      input logic [ADDR_BITS-1:0] a
   );
      return (a == LAST) ? '0 : a + ADDR_BITS'(1);
   endfunction

   assign row_ok = bus.clr_row_req && (bus.clr_row_start <= LAST);

   assign bus.cmd_ready = (state == IDLE) && !bus.clr_row_req
                          && !bus.clr_all_req && !reset;
   assign bus.clr_busy  = (state != IDLE);
   assign bus.clr_done  = done;
   assign bus.buf_wen   = wen;
   assign bus.buf_waddr = waddr;
   assign bus.buf_din   = din;

   always_comb begin
      state_n      = state;
      addr_n       = addr;
      cnt_n        = cnt;
      pend_n       = pend;
      pend_start_n = pend_start;
      wen_n        = 1'b0;
      waddr_n      = waddr;
      din_n        = din;
      done_n       = 1'b0;
      wr           = 1'b0;
      fresh        = 1'b0;
      wr_addr      = addr;

      unique case (state)
         IDLE: begin
            if (bus.clr_all_req) begin
               state_n = CLR_ALL;
               pend_n  = 1'b0;
               wr      = 1'b1;
               fresh   = 1'b1;
               wr_addr = '0;
            end else if (row_ok) begin
               state_n = CLR_ROW;
               wr      = 1'b1;
               fresh   = 1'b1;
               wr_addr = bus.clr_row_start;
            end else if (bus.cmd_valid && bus.cmd_ready) begin
               // Out-of-range commands are consumed but never written.
               wen_n   = (bus.cmd_addr <= LAST);
               waddr_n = bus.cmd_addr;
               din_n   = bus.cmd_char;
            end
         end
         CLR_ROW: begin
            if (bus.clr_all_req) begin
               state_n = CLR_ALL;
               pend_n  = 1'b0;
               wr      = 1'b1;
               fresh   = 1'b1;
               wr_addr = '0;
            end else begin
               if (row_ok) begin
                  pend_n       = 1'b1;
                  pend_start_n = bus.clr_row_start;
               end
               if (cnt == CW'(COLS)) begin
                  done_n = 1'b1;
                  // A queued row starts back-to-back with this done.
                  if (row_ok || pend) begin
                     pend_n  = 1'b0;
                     wr      = 1'b1;
                     fresh   = 1'b1;
                     wr_addr = row_ok ? bus.clr_row_start
                                      : pend_start;
                  end else begin
                     state_n = IDLE;
                  end
               end else begin
                  wr = 1'b1;
               end
            end
         end
         CLR_ALL: begin
            pend_n = 1'b0;
            if (cnt == CW'(N)) begin
               done_n  = 1'b1;
               state_n = IDLE;
            end else begin
               wr = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase

      if (wr) begin
         wen_n   = 1'b1;
         waddr_n = wr_addr;
         din_n   = FILL_CHAR;
         addr_n  = wrap(wr_addr);
         cnt_n   = fresh ? CW'(1) : cnt + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         addr       <= '0;
         cnt        <= '0;
         pend       <= 1'b0;
         pend_start <= '0;
         wen        <= 1'b0;
         waddr      <= '0;
         din        <= '0;
         done       <= 1'b0;
      end else begin
         state      <= state_n;
         addr       <= addr_n;
         cnt        <= cnt_n;
         pend       <= pend_n;
         pend_start <= pend_start_n;
         wen        <= wen_n;
         waddr      <= waddr_n;
         din        <= din_n;
         done       <= done_n;
      end
   end
endmodule
